// File: rtl/huffman_pkg.sv
// Shared constants, table-entry field offsets, FSM state type and
// the per-entry prefix-match helper for the Huffman decoder.
package huffman_pkg;

    localparam int SYM_W  = 6;
    localparam int CODE_W = 8;
    localparam int LEN_W  = 4;
    localparam int WORD_W = 32;
    localparam int BUF_W  = 64;
    localparam int FILL_W = 7;
    localparam int N_ENT  = 64;

    // Table-entry write word layout
    localparam int ENT_ADDR_LSB = 0;
    localparam int ENT_LEN_LSB  = 6;
    localparam int ENT_CODE_LSB = 10;

    // Control write word layout
    localparam int CTRL_BIT  = 31;
    localparam int CTRL_CLR  = 0;
    localparam int CTRL_INV  = 1;
    localparam int CTRL_STAT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        ERROR  = 2'd3
    } state_e;

    // True when the top len bits of the buffer equal code[len-1:0].
    // Lengths outside 1..8 and lengths above the buffered fill never hit.
    function automatic logic prefix_hit(
        input logic [CODE_W-1:0] code,
        input logic [LEN_W-1:0]  len,
        input logic [CODE_W-1:0] top,
        input logic [FILL_W-1:0] fill
    );
        logic [LEN_W-1:0]  sh;
        logic [CODE_W-1:0] mask;
        sh   = LEN_W'(CODE_W) - len;
        mask = {CODE_W{1'b1}} >> sh;
        return (len != '0)
            && (len <= LEN_W'(CODE_W))
            && (FILL_W'(len) <= fill)
            && ((top >> sh) == (code & mask));
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Avalon-MM slave and symbol-stream signals of the Huffman decoder.
// Ports: chipselect/write/writedata/read/readdata, encoded_in/enable_in/
// ready_out, symbol_out/symbol_valid/error_out. slave = decoder side.
interface huffman_decoder_if;
    import huffman_pkg::*;

    logic              chipselect;
    logic              write;
    logic [WORD_W-1:0] writedata;
    logic              read;
    logic [WORD_W-1:0] readdata;
    logic [WORD_W-1:0] encoded_in;
    logic              enable_in;
    logic              ready_out;
    logic [SYM_W-1:0]  symbol_out;
    logic              symbol_valid;
    logic              error_out;

    modport slave (
        input  chipselect, write, writedata, read,
        input  encoded_in, enable_in,
        output readdata, ready_out,
        output symbol_out, symbol_valid, error_out
    );

    modport master (
        output chipselect, write, writedata, read,
        output encoded_in, enable_in,
        input  readdata, ready_out,
        input  symbol_out, symbol_valid, error_out
    );

endinterface

// File: rtl/huffman_code_table.sv
// 64-entry code table (8-bit code, 4-bit length, valid bit) with a
// parallel prefix match against the buffer head; lowest address wins.
// Ports: clock, resetn, write port (wr_*), inval_all, top_bits, fill
// in; hit, hit_addr, hit_len out.
module huffman_code_table
    import huffman_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [SYM_W-1:0]  wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              inval_all,
    input  logic [CODE_W-1:0] top_bits,
    input  logic [FILL_W-1:0] fill,
    output logic              hit,
    output logic [SYM_W-1:0]  hit_addr,
    output logic [LEN_W-1:0]  hit_len
);

    logic [CODE_W-1:0] code_q [N_ENT];
    logic [LEN_W-1:0]  len_q  [N_ENT];
    logic [N_ENT-1:0]  vld_q;
    logic [N_ENT-1:0]  vld_d;
    logic [N_ENT-1:0]  match;

    always_comb begin
        vld_d = vld_q;
        if (inval_all) begin
            vld_d = '0;
        end
        if (wr_en) begin
            vld_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Entry payload needs no reset: the valid bit gates it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            code_q[wr_addr] <= wr_code;
            len_q[wr_addr]  <= wr_len;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ENT; i++) begin
            match[i] = vld_q[i]
                && prefix_hit(code_q[i], len_q[i], top_bits, fill);
        end
    end

    // Scan downward so the lowest matching address is the last write.
    always_comb begin
        hit      = 1'b0;
        hit_addr = '0;
        hit_len  = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_addr = SYM_W'(i);
                hit_len  = len_q[i];
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Table-driven Huffman decoder: 64-bit MSB-aligned bit buffer fed by
// 32-bit words, one symbol per cycle, Avalon-MM table load and status.
// Ports: clock, resetn, bus (huffman_decoder_if.slave).
// Optional HUFF_DEC_STATS_EN adds a 16-bit symbol counter in readdata.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    huffman_decoder_if.slave bus
);

    state_e            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d, buf_mid;
    logic [FILL_W-1:0] fill_q, fill_d, fill_mid;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic              symv_q, symv_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [15:0]       stat;

    logic              wr, rd, ctrl_wr, ent_wr;
    logic              ctrl_clr, ctrl_inv;
    logic              ready, accept, drop, do_dec;
    logic              hit;
    logic [SYM_W-1:0]  hit_addr;
    logic [LEN_W-1:0]  hit_len;
    logic              wd_unused;

    assign wr       = bus.chipselect & bus.write;
    assign rd       = bus.chipselect & bus.read;
    assign ctrl_wr  = wr & bus.writedata[CTRL_BIT];
    assign ent_wr   = wr & ~bus.writedata[CTRL_BIT];
    assign ctrl_clr = ctrl_wr & bus.writedata[CTRL_CLR];
    assign ctrl_inv = ctrl_wr & bus.writedata[CTRL_INV];

    assign ready  = (fill_q <= FILL_W'(WORD_W)) && (state_q != ERROR);
    assign accept = bus.enable_in & ready;
    assign drop   = bus.enable_in & ~ready;
    assign do_dec = (state_q == DECODE) & hit;

    assign wd_unused = ^{bus.writedata[30:18], bus.writedata[CTRL_STAT]};

    huffman_code_table u_table (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (ent_wr),
        .wr_addr   (bus.writedata[ENT_ADDR_LSB +: SYM_W]),
        .wr_code   (bus.writedata[ENT_CODE_LSB +: CODE_W]),
        .wr_len    (bus.writedata[ENT_LEN_LSB +: LEN_W]),
        .inval_all (ctrl_inv),
        .top_bits  (buf_q[BUF_W-1 -: CODE_W]),
        .fill      (fill_q),
        .hit       (hit),
        .hit_addr  (hit_addr),
        .hit_len   (hit_len)
    );

    always_comb begin
        buf_mid  = buf_q;
        fill_mid = fill_q;
        if (do_dec) begin
            buf_mid  = buf_q << hit_len;
            fill_mid = fill_q - FILL_W'(hit_len);
        end

        // New word lands directly below whatever survives the consume.
        buf_d  = buf_mid;
        fill_d = fill_mid;
        if (accept) begin
            buf_d  = buf_mid
                   | ({bus.encoded_in, {WORD_W{1'b0}}} >> fill_mid);
            fill_d = fill_mid + FILL_W'(WORD_W);
        end

        state_d = state_q;
        err_d   = err_q;
        ovf_d   = ovf_q | drop;
        symv_d  = do_dec;
        sym_d   = do_dec ? hit_addr : sym_q;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = DECODE;
            end
            DECODE: begin
                if (do_dec) begin
                    if (fill_d == '0) state_d = IDLE;
                end else if (fill_q >= FILL_W'(CODE_W)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else if (!accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (accept || ent_wr) state_d = DECODE;
            end
            ERROR: begin
                state_d = ERROR;
            end
        endcase

        if (ctrl_clr) begin
            buf_d   = '0;
            fill_d  = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end

        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = {err_q, ovf_q, fill_q, 7'b0, stat};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sym_q   <= '0;
            symv_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            sym_q   <= sym_d;
            symv_q  <= symv_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef HUFF_DEC_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'(symv_d);
        if (ctrl_wr && bus.writedata[CTRL_STAT]) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat = cnt_q;
`else
    assign stat = '0;
`endif

    assign bus.readdata     = rdata_q;
    assign bus.ready_out    = ready;
    assign bus.symbol_out   = sym_q;
    assign bus.symbol_valid = symv_q;
    assign bus.error_out    = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder.
// Expected values are hand-derived from the code tables used below.
module tb_huffman_decoder;
    import huffman_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    huffman_decoder_if bus();

    huffman_decoder dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [SYM_W-1:0] syms[$];
    int max_fill = 0;

    always @(negedge clk) begin
        if (bus.symbol_valid) syms.push_back(bus.symbol_out);
        if (int'(dut.fill_q) > max_fill) max_fill = int'(dut.fill_q);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] w);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.writedata  = w;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_rd(output logic [31:0] r);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        tick();
        r = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        while (!bus.ready_out && n < 200) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(bus.ready_out), 32'd1);
        bus.enable_in  = 1'b1;
        bus.encoded_in = w;
        tick();
        bus.enable_in  = 1'b0;
    endtask

    function automatic logic [31:0] entry(input int addr, input int code,
                                          input int len);
        return (32'(code & 8'hFF) << 10) | (32'(len & 4'hF) << 6)
             | 32'(addr & 6'h3F);
    endfunction

    function automatic int count_val(input int from, input int num,
                                     input int val);
        int c;
        c = 0;
        for (int i = from; i < from + num && i < syms.size(); i++) begin
            if (int'(syms[i]) == val) c++;
        end
        return c;
    endfunction

    initial begin
        logic [31:0] r;
        int base;

        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.writedata  = '0;
        bus.encoded_in = '0;
        bus.enable_in  = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;

        // Reset state
        check("rst_ready", 32'(bus.ready_out), 32'd1);
        check("rst_symv", 32'(bus.symbol_valid), 32'd0);
        check("rst_sym", 32'(bus.symbol_out), 32'd0);
        check("rst_err", 32'(bus.error_out), 32'd0);
        check("rst_rdata", bus.readdata, 32'd0);

        // Basic decode; entry 60 duplicates entry 0 to exercise priority
        bus_wr(entry(0, 0, 1));
        bus_wr(entry(1, 2, 2));
        bus_wr(entry(2, 3, 2));
        bus_wr(entry(60, 0, 1));
        base = syms.size();
        send(32'hB000_0000);
        repeat (40) tick();
        check("t24_count", 32'(syms.size() - base), 32'd30);
        check("t24_sym0", 32'(count_val(base, 1, 1)), 32'd1);
        check("t24_sym1", 32'(count_val(base + 1, 1, 2)), 32'd1);
        check("t24_zeros", 32'(count_val(base + 2, 28, 0)), 32'd28);
        check("t24_state", 32'(dut.state_q), 32'(IDLE));
        bus_rd(r);
        check("t24_fill", 32'(r[29:23]), 32'd0);
`ifdef HUFF_DEC_STATS_EN
        check("t29_stats", 32'(r[15:0]), 32'd30);
`else
        check("t29_nostats", 32'(r[15:0]), 32'd0);
`endif

        // Back-to-back words with a simultaneous consume and accept
        base = syms.size();
        bus.enable_in  = 1'b1;
        bus.encoded_in = 32'hFFFF_FFFF;
        tick();
        check("t25_ready2", 32'(bus.ready_out), 32'd1);
        bus.encoded_in = 32'h0000_0000;
        tick();
        bus.enable_in = 1'b0;
        check("t25_fill62", 32'(dut.fill_q), 32'd62);
        repeat (60) tick();
        check("t25_count", 32'(syms.size() - base), 32'd48);
        check("t25_twos", 32'(count_val(base, 16, 2)), 32'd16);
        check("t25_zeros", 32'(count_val(base + 16, 32, 0)), 32'd32);
        bus_rd(r);
        check("t25_ovf", 32'(r[30]), 32'd0);
        check("t25_fill", 32'(r[29:23]), 32'd0);

        // Empty table (only lengths 0 and 9) -> decode error
        bus_wr(32'h8000_0002);
        bus_wr(entry(4, 0, 0));
        bus_wr(entry(6, 8'h12, 9));
        send(32'h1234_5678);
        check("t26_err_early", 32'(bus.error_out), 32'd0);
        tick();
        check("t26_err", 32'(bus.error_out), 32'd1);
        check("t26_ready", 32'(bus.ready_out), 32'd0);
        bus_rd(r);
        check("t26_status", 32'(r[31:16]), 32'h9000);
        bus_wr(32'h8000_0001);
        check("t26_err_clr", 32'(bus.error_out), 32'd0);
        check("t26_idle", 32'(dut.state_q), 32'(IDLE));
        check("t26_ready_clr", 32'(bus.ready_out), 32'd1);

        // Overflow with 8-bit codes
        bus_wr(32'h8000_0003);
        bus_wr(entry(5, 0, 8));
        base = syms.size();
        bus.enable_in  = 1'b1;
        bus.encoded_in = 32'h0;
        repeat (4) tick();
        bus.enable_in = 1'b0;
        repeat (20) tick();
        bus_rd(r);
        check("t27_ovf", 32'(r[30]), 32'd1);
        check("t27_count", 32'(syms.size() - base), 32'd8);
        check("t27_sym5", 32'(count_val(base, 8, 5)), 32'd8);

        // Read together with a clearing write sees pre-write state
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b1;
        bus.writedata  = 32'h8000_0001;
        tick();
        r = bus.readdata;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        check("rw_before", 32'(r[31:16]), 32'h4000);
        bus_rd(r);
        check("rw_after", 32'(r[31:16]), 32'h0000);

        // Reset in the middle of a decode
        bus_wr(32'h8000_0002);
        bus_wr(entry(0, 0, 1));
        bus_wr(entry(1, 2, 2));
        bus_wr(entry(2, 3, 2));
        send(32'hB000_0000);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        base = syms.size();
        check("t28_rdata", bus.readdata, 32'd0);
        check("t28_symv", 32'(bus.symbol_valid), 32'd0);
        check("t28_sym", 32'(bus.symbol_out), 32'd0);
        check("t28_ready", 32'(bus.ready_out), 32'd1);
        repeat (10) tick();
        check("t28_nosym", 32'(syms.size() - base), 32'd0);

        // Table was wiped by reset; reload and decode again
        bus_wr(entry(0, 0, 1));
        bus_wr(entry(9, 8'h0B, 4));
        base = syms.size();
        send(32'hB000_0000);
        repeat (40) tick();
        check("t28_count", 32'(syms.size() - base), 32'd29);
        check("t28_first", 32'(count_val(base, 1, 9)), 32'd1);
        check("t28_zeros", 32'(count_val(base + 1, 28, 0)), 32'd28);
        check("t28_err", 32'(bus.error_out), 32'd0);

        check("fill_max", 32'(max_fill <= 64), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
